// File: rtl/timer_regresivo_bcd_if.sv
// Control/data bundle between the edit/cursor logic and the countdown timer.
// Inputs are one-cycle strobes plus BCD load values; outputs are registered digits and status.
interface timer_regresivo_bcd_if;
  logic       load;
  logic [7:0] load_HORA;
  logic [7:0] load_MIN;
  logic [7:0] load_SEG;
  logic       start;
  logic       stop;
  logic       alarm_ack;
  logic [7:0] digit_TimerHORA;
  logic [7:0] digit_TimerMIN;
  logic [7:0] digit_TimerSEG;
  logic       Alarma_on;
  logic       running;
  logic       load_err;
  logic [1:0] fsm_state;

  modport master (
    output load, load_HORA, load_MIN, load_SEG, start, stop, alarm_ack,
    input  digit_TimerHORA, digit_TimerMIN, digit_TimerSEG,
    input  Alarma_on, running, load_err, fsm_state
  );

  modport slave (
    input  load, load_HORA, load_MIN, load_SEG, start, stop, alarm_ack,
    output digit_TimerHORA, digit_TimerMIN, digit_TimerSEG,
    output Alarma_on, running, load_err, fsm_state
  );
endinterface

// File: rtl/timer_regresivo_bcd.sv
// HH:MM:SS packed-BCD countdown timer with a one-second prescaler and an alarm at 00:00:00.
// Strobes are single-cycle; priority within a cycle is alarm_ack > stop > start > load.
module timer_regresivo_bcd #(
  parameter int TICK_DIV = 25000000,
  parameter int CNT_W    = 25
) (
  input logic                  CLK,
  input logic                  RESET,
  timer_regresivo_bcd_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  state_t           state;
  logic [CNT_W-1:0] pre;
  logic [23:0]      hms;
  logic             alarm;
  logic             run_q;
  logic             err_q;
  logic [23:0]      load_val;
  logic [23:0]      hms_dec;
  logic             load_ok;

  // Borrow chain works nibble by nibble so only BCD codes ever appear.
  function automatic logic [23:0] dec_time(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    if (s0 != 4'd0) s0 = s0 - 4'd1;
    else begin
      s0 = 4'd9;
      if (s1 != 4'd0) s1 = s1 - 4'd1;
      else begin
        s1 = 4'd5;
        if (m0 != 4'd0) m0 = m0 - 4'd1;
        else begin
          m0 = 4'd9;
          if (m1 != 4'd0) m1 = m1 - 4'd1;
          else begin
            m1 = 4'd5;
            if (h0 != 4'd0) h0 = h0 - 4'd1;
            else begin
              h0 = 4'd9;
              h1 = h1 - 4'd1;
            end
          end
        end
      end
    end
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  function automatic logic valid_time(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    return (h0 <= 4'd9) && (m1 <= 4'd5) && (m0 <= 4'd9) &&
           (s1 <= 4'd5) && (s0 <= 4'd9) && ({h1, h0} <= 8'h23);
  endfunction

  always_comb begin
    load_val = {bus.load_HORA, bus.load_MIN, bus.load_SEG};
    load_ok  = valid_time(load_val);
    hms_dec  = dec_time(hms);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      pre   <= '0;
      hms   <= 24'h000000;
      alarm <= 1'b0;
      run_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE, PAUSE: begin
          if (bus.alarm_ack || bus.stop) begin
            // higher-priority strobe with no effect here still masks start/load
          end else if (bus.start) begin
            if (hms != 24'h000000) begin
              state <= RUN;
              run_q <= 1'b1;
              // A resume keeps the frozen prescaler so no tick is gained or lost.
              if (state == IDLE) pre <= '0;
            end
          end else if (bus.load) begin
            if (load_ok) hms <= load_val;
            else err_q <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.alarm_ack && bus.stop) begin
            state <= PAUSE;
            run_q <= 1'b0;
          end else if (pre == TICK_LAST) begin
            pre <= '0;
            hms <= hms_dec;
            if (hms_dec == 24'h000000) begin
              state <= ALARM;
              alarm <= 1'b1;
              run_q <= 1'b0;
            end
          end else begin
            pre <= pre + CNT_W'(1);
          end
        end
        ALARM: begin
          if (bus.alarm_ack) begin
            state <= IDLE;
            alarm <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.digit_TimerHORA = hms[23:16];
  assign bus.digit_TimerMIN  = hms[15:8];
  assign bus.digit_TimerSEG  = hms[7:0];
  assign bus.Alarma_on       = alarm;
  assign bus.running         = run_q;
  assign bus.load_err        = err_q;
  assign bus.fsm_state       = state;

endmodule

// File: tb/tb_timer_regresivo_bcd.sv
// Directed bench for the BCD countdown timer with TICK_DIV=4: a per-cycle vector table
// followed by hand-written alarm, pause/resume and asynchronous-reset sequences.
module tb_timer_regresivo_bcd;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_ALARM = 2'd3;
  localparam int W = 29;

  typedef struct {
    logic        ld;
    logic [23:0] ld_val;
    logic        st;
    logic        sp;
    logic        ack;
    logic [23:0] exp_hms;
    logic [1:0]  exp_state;
    logic        exp_err;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [W-1:0] exp_q[$];
  vec_t vq[$];

  timer_regresivo_bcd_if bus();

  timer_regresivo_bcd #(.TICK_DIV(4), .CNT_W(3)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // driver: strobes are held for exactly one rising edge
  task automatic drive_cycle(input logic ld, input logic [23:0] val,
                             input logic st, input logic sp, input logic ack);
    @(negedge clk);
    bus.load      = ld;
    {bus.load_HORA, bus.load_MIN, bus.load_SEG} = val;
    bus.start     = st;
    bus.stop      = sp;
    bus.alarm_ack = ack;
    @(posedge clk);
    #1;
    bus.load      = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.alarm_ack = 1'b0;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // scoreboard: alarm and running follow directly from the expected state
  task automatic check_out(input string name, input logic [23:0] e_hms,
                           input logic [1:0] e_state, input logic e_err);
    logic [W-1:0] exp_w;
    logic [W-1:0] act_w;
    exp_q.push_back({e_hms, e_state, (e_state == S_ALARM), (e_state == S_RUN), e_err});
    exp_w = exp_q.pop_front();
    act_w = {bus.digit_TimerHORA, bus.digit_TimerMIN, bus.digit_TimerSEG,
             bus.fsm_state, bus.Alarma_on, bus.running, bus.load_err};
    tests++;
    if (act_w !== exp_w) begin
      fails++;
      $display("FAIL %s: got hms=%h st=%0d al=%b run=%b err=%b, want hms=%h st=%0d al=%b run=%b err=%b",
               name, act_w[28:5], act_w[4:3], act_w[2], act_w[1], act_w[0],
               exp_w[28:5], exp_w[4:3], exp_w[2], exp_w[1], exp_w[0]);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [23:0] val, input logic st,
                              input logic sp, input logic ack, input logic [23:0] e_hms,
                              input logic [1:0] e_state, input logic e_err);
    vec_t v;
    v.ld = ld; v.ld_val = val; v.st = st; v.sp = sp; v.ack = ack;
    v.exp_hms = e_hms; v.exp_state = e_state; v.exp_err = e_err;
    return v;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    bus.load = 1'b0; bus.load_HORA = 8'h00; bus.load_MIN = 8'h00; bus.load_SEG = 8'h00;
    bus.start = 1'b0; bus.stop = 1'b0; bus.alarm_ack = 1'b0;

    // one row per clock edge; expected values after that edge
    vq.push_back(mk(1, 24'h000100, 0, 0, 0, 24'h000100, S_IDLE,  0));
    vq.push_back(mk(0, 24'h0,      1, 0, 0, 24'h000100, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h000100, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h000100, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h000100, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h000059, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h000059, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h000059, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h000059, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h000058, S_RUN,   0));
    vq.push_back(mk(1, 24'h000000, 0, 0, 0, 24'h000058, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      1, 1, 0, 24'h000058, S_PAUSE, 0));
    vq.push_back(mk(1, 24'h240000, 0, 0, 0, 24'h000058, S_PAUSE, 1));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h000058, S_PAUSE, 0));
    vq.push_back(mk(1, 24'h006000, 0, 0, 0, 24'h000058, S_PAUSE, 1));
    vq.push_back(mk(1, 24'h00001A, 0, 0, 0, 24'h000058, S_PAUSE, 1));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h000058, S_PAUSE, 0));
    vq.push_back(mk(1, 24'h010000, 0, 0, 0, 24'h010000, S_PAUSE, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 0, 24'h010000, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h010000, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h010000, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h005959, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 1, 0, 24'h005959, S_PAUSE, 0));
    vq.push_back(mk(0, 24'h0,      0, 0, 1, 24'h005959, S_PAUSE, 0));
    vq.push_back(mk(1, 24'h000000, 0, 0, 0, 24'h000000, S_PAUSE, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 0, 24'h000000, S_PAUSE, 0));
    vq.push_back(mk(1, 24'h100000, 0, 0, 0, 24'h100000, S_PAUSE, 0));
    vq.push_back(mk(0, 24'h0,      1, 0, 0, 24'h100000, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h100000, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h100000, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h100000, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 0, 0, 24'h095959, S_RUN,   0));
    vq.push_back(mk(0, 24'h0,      0, 1, 0, 24'h095959, S_PAUSE, 0));
    vq.push_back(mk(1, 24'h235959, 0, 0, 0, 24'h235959, S_PAUSE, 0));
    vq.push_back(mk(1, 24'h300000, 0, 0, 0, 24'h235959, S_PAUSE, 1));

    rst = 1'b1;
    #1;
    check_out("reset_async", 24'h000000, S_IDLE, 0);
    do_reset();
    check_out("reset_idle", 24'h000000, S_IDLE, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive_cycle(vq[i].ld, vq[i].ld_val, vq[i].st, vq[i].sp, vq[i].ack);
      check_out($sformatf("vec%0d", i), vq[i].exp_hms, vq[i].exp_state, vq[i].exp_err);
    end

    // alarm: 00:00:02 reaches 00:00:00 after two ticks, then ack
    do_reset();
    drive_cycle(1, 24'h000002, 0, 0, 0);
    check_out("alm_load", 24'h000002, S_IDLE, 0);
    drive_cycle(0, 24'h0, 1, 0, 0);
    check_out("alm_start", 24'h000002, S_RUN, 0);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      check_out($sformatf("alm_hold%0d", i), 24'h000002, S_RUN, 0);
    end
    idle_cycle();
    check_out("alm_tick1", 24'h000001, S_RUN, 0);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      check_out($sformatf("alm_wait%0d", i), 24'h000001, S_RUN, 0);
    end
    idle_cycle();
    check_out("alm_zero", 24'h000000, S_ALARM, 0);
    idle_cycle();
    check_out("alm_stay", 24'h000000, S_ALARM, 0);
    drive_cycle(0, 24'h0, 1, 0, 0);
    check_out("alm_start_ign", 24'h000000, S_ALARM, 0);
    drive_cycle(1, 24'h000500, 0, 0, 0);
    check_out("alm_load_ign", 24'h000000, S_ALARM, 0);
    drive_cycle(0, 24'h0, 0, 0, 1);
    check_out("alm_ack", 24'h000000, S_IDLE, 0);

    // pause at prescaler=2: the resume tick lands two edges after start
    do_reset();
    drive_cycle(1, 24'h000030, 0, 0, 0);
    drive_cycle(0, 24'h0, 1, 0, 0);
    idle_cycle();
    idle_cycle();
    drive_cycle(0, 24'h0, 0, 1, 0);
    check_out("pause_stop", 24'h000030, S_PAUSE, 0);
    for (int i = 0; i < 10; i++) begin
      idle_cycle();
      if (i == 9) check_out("pause_hold", 24'h000030, S_PAUSE, 0);
    end
    drive_cycle(0, 24'h0, 1, 0, 0);
    check_out("resume_start", 24'h000030, S_RUN, 0);
    idle_cycle();
    check_out("resume_1", 24'h000030, S_RUN, 0);
    idle_cycle();
    check_out("resume_2", 24'h000029, S_RUN, 0);

    // asynchronous reset while counting at 00:10:07
    do_reset();
    drive_cycle(1, 24'h001007, 0, 0, 0);
    drive_cycle(0, 24'h0, 1, 0, 0);
    for (int i = 0; i < 4; i++) idle_cycle();
    check_out("midrun_tick", 24'h001006, S_RUN, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_out("midrun_rst", 24'h000000, S_IDLE, 0);
    @(posedge clk);
    #1;
    check_out("midrun_rst_hold", 24'h000000, S_IDLE, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) idle_cycle();
    check_out("after_rst", 24'h000000, S_IDLE, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
